core_decode_ldst_misc_exec: RTL

CORE_DECODE_LDST_MISC_EXEC -- requirements
Module: core_ldst_misc_exec

---
 rtl/core_decode_ldst_misc_exec.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/core_decode_ldst_misc_exec.sv
// ---------------------------------------------------------------------------
// core_decode_ldst_misc_exec
//
// Purpose: execution unit for the miscellaneous load/store class, covering
// halfword, signed-byte and signed-halfword loads, and halfword and byte
// stores. One operation is accepted at a time. It runs one bus transaction and
// then commits the data register and/or the base register.
//
// Ports:
//   clk, rst          - clock (rising edge); asynchronous active-high reset
//   start             - accept one operation (ignored while busy)
//   load/half/sign_extend/increment/pre_indexed/writeback - operation controls
//   rn, rd            - base / data register numbers
//   rn_value, rd_value, offset - base value, store data, resolved offset
//   busy              - high in every state except IDLE
//   bus_start         - one-cycle request strobe
//   bus_addr          - word address (byte address [31:2])
//   bus_write, bus_data_wr, bus_be - transaction direction, data, byte enables
//   bus_ready, bus_data_rd - completion strobe and read data
//   done, fault       - one-cycle commit strobe, alignment fault flag
//   rd_wr_en/num/value, rn_wr_en/num/value - register write-back ports
//
// Configuration:
//   CORE_LDST_MISC_ALIGN_CHECK_EN - when defined, a halfword access with an
//   odd byte address skips the bus and commits as a fault with no register
//   writes. When undefined, addr[0] is ignored and fault is always 0.
// ---------------------------------------------------------------------------
module core_decode_ldst_misc_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load,
  input  logic        half,
  input  logic        sign_extend,
  input  logic        increment,
  input  logic        pre_indexed,
  input  logic        writeback,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [31:0] rn_value,
  input  logic [31:0] rd_value,
  input  logic [31:0] offset,
  output logic        busy,
  output logic        bus_start,
  output logic [29:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_data_wr,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_data_rd,
  output logic        done,
  output logic        fault,
  output logic        rd_wr_en,
  output logic [3:0]  rd_wr_num,
  output logic [31:0] rd_wr_value,
  output logic        rn_wr_en,
  output logic [3:0]  rn_wr_num,
  output logic [31:0] rn_wr_value
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Select the addressed lane of a read word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input logic        is_half,
                                               input logic        sext);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lane[1] ? data[31:16] : data[15:0];
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      2'd3:    b = data[31:24];
      default: b = 8'h00;
    endcase
    if (is_half) begin
      r = sext ? {{16{h[15]}}, h} : {16'h0000, h};
    end else begin
      r = sext ? {{24{b[7]}}, b} : {24'h000000, b};
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;
  logic        load_q, load_d;
  logic        half_q, half_d;
  logic        sext_q, sext_d;
  logic        wb_q, wb_d;
  logic [3:0]  rn_q, rn_d;
  logic [3:0]  rd_q, rd_d;
  logic [31:0] offs_addr_q, offs_addr_d;
  logic        misalign_q, misalign_d;
  logic        busy_q, busy_d;
  logic        bus_start_q, bus_start_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        rd_wr_en_q, rd_wr_en_d;
  logic        rn_wr_en_q, rn_wr_en_d;
  logic [31:0] rd_wr_value_q, rd_wr_value_d;

  logic [31:0] offset_addr_s;
  logic [31:0] eff_addr_s;
  logic        misalign_s;

  // Address arithmetic on the live operands, used only on the accept cycle.
  always_comb begin
    offset_addr_s = increment ? (rn_value + offset) : (rn_value - offset);
    eff_addr_s    = pre_indexed ? offset_addr_s : rn_value;
`ifdef CORE_LDST_MISC_ALIGN_CHECK_EN
    misalign_s    = half & eff_addr_s[0];
`else
    misalign_s    = 1'b0;
`endif
  end

  // Next-state, operand capture and registered-output computation.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    write_d       = write_q;
    load_d        = load_q;
    half_d        = half_q;
    sext_d        = sext_q;
    wb_d          = wb_q;
    rn_d          = rn_q;
    rd_d          = rd_q;
    offs_addr_d   = offs_addr_q;
    misalign_d    = misalign_q;
    rd_wr_value_d = rd_wr_value_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_REQ;
          addr_d      = eff_addr_s;
          write_d     = ~load;
          load_d      = load;
          half_d      = half;
          sext_d      = sign_extend;
          wb_d        = writeback;
          rn_d        = rn;
          rd_d        = rd;
          offs_addr_d = offset_addr_s;
          misalign_d  = misalign_s;
          if (load) begin
            wdata_d = 32'h0000_0000;
            be_d    = 4'b1111;
          end else if (half) begin
            wdata_d = {rd_value[15:0], rd_value[15:0]};
            be_d    = eff_addr_s[1] ? 4'b1100 : 4'b0011;
          end else begin
            wdata_d = {4{rd_value[7:0]}};
            be_d    = 4'b0001 << eff_addr_s[1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // A misaligned access never reaches the bus.
      ST_REQ: begin
        state_d = misalign_q ? ST_COMMIT : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_ready) begin
          state_d = ST_COMMIT;
          if (load_q) begin
            rd_wr_value_d = extract_load(bus_data_rd, addr_q[1:0], half_q, sext_q);
          end else begin
            rd_wr_value_d = rd_wr_value_q;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so that they appear as flops.
    busy_d      = (state_d != ST_IDLE);
    bus_start_d = (state_d == ST_REQ) && !misalign_d;
    done_d      = (state_d == ST_COMMIT);
    fault_d     = done_d && misalign_q;
    rd_wr_en_d  = done_d && load_q && !misalign_q;
    // A load into the base register keeps the loaded value, not the base update.
    rn_wr_en_d  = done_d && wb_q && !misalign_q && !(load_q && (rn_q == rd_q));
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= 32'h0000_0000;
      wdata_q       <= 32'h0000_0000;
      be_q          <= 4'b0000;
      write_q       <= 1'b0;
      load_q        <= 1'b0;
      half_q        <= 1'b0;
      sext_q        <= 1'b0;
      wb_q          <= 1'b0;
      rn_q          <= 4'h0;
      rd_q          <= 4'h0;
      offs_addr_q   <= 32'h0000_0000;
      misalign_q    <= 1'b0;
      busy_q        <= 1'b0;
      bus_start_q   <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      rd_wr_en_q    <= 1'b0;
      rn_wr_en_q    <= 1'b0;
      rd_wr_value_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      write_q       <= write_d;
      load_q        <= load_d;
      half_q        <= half_d;
      sext_q        <= sext_d;
      wb_q          <= wb_d;
      rn_q          <= rn_d;
      rd_q          <= rd_d;
      offs_addr_q   <= offs_addr_d;
      misalign_q    <= misalign_d;
      busy_q        <= busy_d;
      bus_start_q   <= bus_start_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      rd_wr_en_q    <= rd_wr_en_d;
      rn_wr_en_q    <= rn_wr_en_d;
      rd_wr_value_q <= rd_wr_value_d;
    end
  end

  assign busy        = busy_q;
  assign bus_start   = bus_start_q;
  assign bus_addr    = addr_q[31:2];
  assign bus_write   = write_q;
  assign bus_data_wr = wdata_q;
  assign bus_be      = be_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign rd_wr_en    = rd_wr_en_q;
  assign rd_wr_num   = rd_q;
  assign rd_wr_value = rd_wr_value_q;
  assign rn_wr_en    = rn_wr_en_q;
  assign rn_wr_num   = rn_q;
  assign rn_wr_value = offs_addr_q;

endmodule
